// File: rtl/usb_rst_sequencer.sv
// Avalon-MM slave that drives the USB host-controller reset pin with a timed
// assert pulse and recovery wait, once at power-on and again on software START.
module usb_rst_sequencer #(
   parameter int unsigned CNT_W           = 16,
   parameter int unsigned DEFAULT_ASSERT  = 500,
   parameter int unsigned DEFAULT_RECOVER = 5000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        out_port,
   output logic        irq
);

   localparam int unsigned ST_W = 2;
   localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
   localparam logic [ST_W-1:0] ST_ASSERT  = 2'd1;
   localparam logic [ST_W-1:0] ST_RECOVER = 2'd2;

   localparam logic [CNT_W-1:0] RST_ASSERT  = CNT_W'(DEFAULT_ASSERT);
   localparam logic [CNT_W-1:0] RST_RECOVER = CNT_W'(DEFAULT_RECOVER);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_STATUS = 2'd1;
   localparam logic [1:0] A_ALEN   = 2'd2;
   localparam logic [1:0] A_RLEN   = 2'd3;

   // A programmed length of zero still produces a one-cycle phase.
   function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
      return (len == '0) ? CNT_ONE : len;
   endfunction

   logic [ST_W-1:0]  state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] assert_len_q, assert_len_d;
   logic [CNT_W-1:0] recover_len_q, recover_len_d;
   logic [CNT_W-1:0] rec_shadow_q, rec_shadow_d;
   logic             irq_en_q, irq_en_d;
   logic             force_q, force_d;
   logic             done_q, done_d;
   logic             out_port_q, out_port_d;
   logic             irq_q, irq_d;

   logic wr_en, wr_ctrl, wr_status, start_req, busy;
   logic unused_wdata;

   assign wr_en        = chipselect & ~write_n;
   assign wr_ctrl      = wr_en && (address == A_CTRL);
   assign wr_status    = wr_en && (address == A_STATUS);
   assign start_req    = wr_ctrl & writedata[0];
   assign busy         = (state_q != ST_IDLE);
   assign unused_wdata = ^writedata[31:CNT_W];

   // Next-state, counter and register-file update.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      assert_len_d  = assert_len_q;
      recover_len_d = recover_len_q;
      rec_shadow_d  = rec_shadow_q;
      irq_en_d      = irq_en_q;
      force_d       = force_q;
      done_d        = done_q;
      out_port_d    = out_port_q;

      if (wr_ctrl) begin
         irq_en_d = writedata[1];
         force_d  = writedata[2];
      end
      if (wr_en && (address == A_ALEN)) assert_len_d  = writedata[CNT_W-1:0];
      if (wr_en && (address == A_RLEN)) recover_len_d = writedata[CNT_W-1:0];
      if (wr_status && writedata[1]) done_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            out_port_d = ~force_d;
            if (start_req && !force_d) begin
               state_d      = ST_ASSERT;
               cnt_d        = eff_len(assert_len_q);
               rec_shadow_d = eff_len(recover_len_q);
               out_port_d   = 1'b0;
            end
         end
         ST_ASSERT: begin
            out_port_d = 1'b0;
            if (force_d) begin
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_ONE) begin
               state_d    = ST_RECOVER;
               cnt_d      = rec_shadow_q;
               out_port_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_RECOVER: begin
            out_port_d = 1'b1;
            if (force_d) begin
               state_d    = ST_IDLE;
               out_port_d = 1'b0;
            end else if (cnt_q == CNT_ONE) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            out_port_d = ~force_d;
         end
      endcase

      // Completion set takes priority over a coincident W1C clear.
      irq_d = done_d & irq_en_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_ASSERT;
         cnt_q         <= eff_len(RST_ASSERT);
         assert_len_q  <= RST_ASSERT;
         recover_len_q <= RST_RECOVER;
         rec_shadow_q  <= eff_len(RST_RECOVER);
         irq_en_q      <= 1'b0;
         force_q       <= 1'b0;
         done_q        <= 1'b0;
         out_port_q    <= 1'b0;
         irq_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         assert_len_q  <= assert_len_d;
         recover_len_q <= recover_len_d;
         rec_shadow_q  <= rec_shadow_d;
         irq_en_q      <= irq_en_d;
         force_q       <= force_d;
         done_q        <= done_d;
         out_port_q    <= out_port_d;
         irq_q         <= irq_d;
      end
   end

   // Zero-wait-state read mux; unused bits read as zero.
   always_comb begin
      readdata = '0;
      case (address)
         A_CTRL:   readdata = {29'd0, force_q, irq_en_q, 1'b0};
         A_STATUS: readdata = {29'd0, ~out_port_q, done_q, busy};
         A_ALEN:   readdata = 32'(assert_len_q);
         A_RLEN:   readdata = 32'(recover_len_q);
         default:  readdata = '0;
      endcase
   end

   assign out_port = out_port_q;
   assign irq      = irq_q;

endmodule
